// File: rtl/echo_pkg.sv
// Shared definitions for the host echo engine: transform mode encodings and
// a constant-evaluable ceil(log2) helper used to size pointers and levels.
package echo_pkg;

    typedef enum logic [1:0] {
        ECHO_PASS = 2'b00,
        ECHO_INV  = 2'b01,
        ECHO_INC  = 2'b10,
        ECHO_CASE = 2'b11
    } echo_mode_e;

    localparam int LAG_WIDTH = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/echo_engine_if.sv
// Host FIFO handshake bundle between HostIoComm (master) and the echo engine
// (slave); suffixes are named from the engine's point of view.
interface echo_engine_if #(
    parameter int DATA_WIDTH_G  = 8,
    parameter int LEVEL_WIDTH_G = 3,
    parameter int COUNT_WIDTH_G = 16
);
    logic                     enable_i;
    logic [1:0]               mode_i;
    logic                     dnEmpty_i;
    logic [DATA_WIDTH_G-1:0]  data_i;
    logic                     rmv_o;
    logic                     upFull_i;
    logic                     add_o;
    logic [DATA_WIDTH_G-1:0]  data_o;
    logic [LEVEL_WIDTH_G-1:0] level_o;
    logic [COUNT_WIDTH_G-1:0] count_o;

    modport master (
        output enable_i, mode_i, dnEmpty_i, data_i, upFull_i,
        input  rmv_o, add_o, data_o, level_o, count_o
    );

    modport slave (
        input  enable_i, mode_i, dnEmpty_i, data_i, upFull_i,
        output rmv_o, add_o, data_o, level_o, count_o
    );

endinterface

// File: rtl/echo_buf_fifo.sv
// Small synchronous FIFO buffering transformed words between capture and emit.
// Callers guarantee no push when full and no pop when empty.
module echo_buf_fifo
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH_G = 8,
    parameter int DEPTH_G      = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       push_i,
    input  logic [DATA_WIDTH_G-1:0]    data_i,
    input  logic                       pop_i,
    output logic [DATA_WIDTH_G-1:0]    data_o,
    output logic [clog2(DEPTH_G):0]    level_o
);

    localparam int PTR_W = clog2(DEPTH_G);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH_G-1:0] mem_q [DEPTH_G];
    logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]        level_q, level_d;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wrPtr_d = push_i ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = pop_i  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        level_d = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign level_o = level_q;

endmodule

// File: rtl/echo_engine.sv
// Echo engine: drains the host-to-FPGA FIFO, transforms each word, buffers it
// and pushes it back upstream, pacing both FIFO strobes for status settling.
module echo_engine
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH_G  = 8,
    parameter int DEPTH_G       = 4,
    parameter int STATUS_LAG_G  = 1,
    parameter int COUNT_WIDTH_G = 16
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    echo_engine_if.slave  bus
);

    localparam int LVL_W = clog2(DEPTH_G) + 1;
    localparam logic [LAG_WIDTH-1:0]    LAG_INIT = LAG_WIDTH'(STATUS_LAG_G);
    localparam logic [DATA_WIDTH_G-1:0] UP_A  = DATA_WIDTH_G'(8'h41);
    localparam logic [DATA_WIDTH_G-1:0] UP_Z  = DATA_WIDTH_G'(8'h5A);
    localparam logic [DATA_WIDTH_G-1:0] LO_A  = DATA_WIDTH_G'(8'h61);
    localparam logic [DATA_WIDTH_G-1:0] LO_Z  = DATA_WIDTH_G'(8'h7A);
    localparam logic [DATA_WIDTH_G-1:0] CASE_BIT = DATA_WIDTH_G'(8'h20);

    // Case swap only makes sense for byte-wide ASCII words.
    function automatic logic [DATA_WIDTH_G-1:0] transform(
        input logic [DATA_WIDTH_G-1:0] w,
        input logic [1:0]              m
    );
        logic [DATA_WIDTH_G-1:0] r;
        r = w;
        case (echo_mode_e'(m))
            ECHO_PASS: r = w;
            ECHO_INV:  r = ~w;
            ECHO_INC:  r = w + DATA_WIDTH_G'(1);
            ECHO_CASE: begin
                if ((DATA_WIDTH_G == 8) &&
                    (((w >= UP_A) && (w <= UP_Z)) || ((w >= LO_A) && (w <= LO_Z)))) begin
                    r = w ^ CASE_BIT;
                end
            end
            default:   r = w;
        endcase
        return r;
    endfunction

    logic                     push, pop;
    logic [DATA_WIDTH_G-1:0]  pushData, headData;
    logic [LVL_W-1:0]         level;

    logic                     rmv_q, rmv_d;
    logic                     add_q, add_d;
    logic [DATA_WIDTH_G-1:0]  data_q, data_d;
    logic [COUNT_WIDTH_G-1:0] count_q, count_d;
    logic [LAG_WIDTH-1:0]     rmvLag_q, rmvLag_d;
    logic [LAG_WIDTH-1:0]     addLag_q, addLag_d;

    assign push     = bus.enable_i && !bus.dnEmpty_i && (level < LVL_W'(DEPTH_G)) && (rmvLag_q == '0);
    assign pop      = (level != '0) && !bus.upFull_i && (addLag_q == '0);
    assign pushData = transform(bus.data_i, bus.mode_i);

    echo_buf_fifo #(
        .DATA_WIDTH_G (DATA_WIDTH_G),
        .DEPTH_G      (DEPTH_G)
    ) u_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .data_i    (pushData),
        .pop_i     (pop),
        .data_o    (headData),
        .level_o   (level)
    );

    // Each strobe reloads its lag counter so the next one waits for flags to settle.
    always_comb begin
        rmv_d    = push;
        add_d    = pop;
        data_d   = data_q;
        count_d  = count_q;
        rmvLag_d = (rmvLag_q == '0) ? '0 : rmvLag_q - LAG_WIDTH'(1);
        addLag_d = (addLag_q == '0) ? '0 : addLag_q - LAG_WIDTH'(1);
        if (push) begin
            rmvLag_d = LAG_INIT;
        end
        if (pop) begin
            data_d   = headData;
            count_d  = count_q + COUNT_WIDTH_G'(1);
            addLag_d = LAG_INIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rmv_q    <= 1'b0;
            add_q    <= 1'b0;
            data_q   <= '0;
            count_q  <= '0;
            rmvLag_q <= '0;
            addLag_q <= '0;
        end else begin
            rmv_q    <= rmv_d;
            add_q    <= add_d;
            data_q   <= data_d;
            count_q  <= count_d;
            rmvLag_q <= rmvLag_d;
            addLag_q <= addLag_d;
        end
    end

    assign bus.rmv_o   = rmv_q;
    assign bus.add_o   = add_q;
    assign bus.data_o  = data_q;
    assign bus.level_o = level;
    assign bus.count_o = count_q;

endmodule

// File: tb/tb_echo_engine.sv
// Bench for echo_engine: two instances (lag 1 / 16-bit count, lag 0 / 8-bit
// count) driven from queue-based host FIFO models and a word-order reference.
module tb_echo_engine;
    import echo_pkg::*;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    echo_engine_if #(.DATA_WIDTH_G(8), .LEVEL_WIDTH_G(3), .COUNT_WIDTH_G(16)) b1();
    echo_engine_if #(.DATA_WIDTH_G(8), .LEVEL_WIDTH_G(3), .COUNT_WIDTH_G(8))  b0();

    echo_engine #(.DATA_WIDTH_G(8), .DEPTH_G(4), .STATUS_LAG_G(1), .COUNT_WIDTH_G(16)) dut1 (
        .clk_i(clk), .reset_n_i(rstN), .bus(b1.slave));
    echo_engine #(.DATA_WIDTH_G(8), .DEPTH_G(4), .STATUS_LAG_G(0), .COUNT_WIDTH_G(8)) dut0 (
        .clk_i(clk), .reset_n_i(rstN), .bus(b0.slave));

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic [7:0] hostQ1[$], hostQ0[$], inFlight1[$], inFlight0[$];
    int rmvPulses1 = 0, addPulses1 = 0, backToBack1 = 0, addsTotal1 = 0;
    int addsTotal0 = 0;
    logic prevRmv1 = 1'b0, prevAdd1 = 1'b0;
    int rmvTicks0[$], addTicks0[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference transform from the ASCII/arithmetic rules, not from the RTL.
    function automatic logic [7:0] refXform(input logic [7:0] w, input logic [1:0] m);
        int v;
        v = int'(w);
        case (m)
            2'd1: v = 255 - v;
            2'd2: v = (v + 1) % 256;
            2'd3: begin
                if (v >= 65 && v <= 90) v = v + 32;
                else if (v >= 97 && v <= 122) v = v - 32;
            end
            default: v = v;
        endcase
        return 8'(v);
    endfunction

    task automatic applyStimulus();
        b1.dnEmpty_i = (hostQ1.size() == 0);
        b1.data_i    = (hostQ1.size() != 0) ? hostQ1[0] : 8'h00;
        b0.dnEmpty_i = (hostQ0.size() == 0);
        b0.data_i    = (hostQ0.size() != 0) ? hostQ0[0] : 8'h00;
    endtask

    task automatic tick();
        logic rstEdge;
        rstEdge = !rstN;
        @(posedge clk);
        #1;
        cycle++;
        if (rstEdge) begin
            inFlight1.delete();
            inFlight0.delete();
            addsTotal1 = 0;
            addsTotal0 = 0;
            prevRmv1 = 1'b0;
            prevAdd1 = 1'b0;
        end else begin
            if (b1.rmv_o) begin
                rmvPulses1++;
                if (hostQ1.size() > 0) inFlight1.push_back(refXform(hostQ1.pop_front(), b1.mode_i));
            end
            if (b1.add_o) begin
                addPulses1++;
                addsTotal1++;
                checkOutput("addHasWord1", 32'(inFlight1.size() != 0), 32'd1);
                if (inFlight1.size() > 0) checkOutput("data1", 32'(b1.data_o), 32'(inFlight1.pop_front()));
            end
            if ((b1.rmv_o && prevRmv1) || (b1.add_o && prevAdd1)) backToBack1++;
            prevRmv1 = b1.rmv_o;
            prevAdd1 = b1.add_o;
            if (b0.rmv_o) begin
                rmvTicks0.push_back(cycle);
                if (hostQ0.size() > 0) inFlight0.push_back(refXform(hostQ0.pop_front(), b0.mode_i));
            end
            if (b0.add_o) begin
                addTicks0.push_back(cycle);
                addsTotal0++;
                checkOutput("addHasWord0", 32'(inFlight0.size() != 0), 32'd1);
                if (inFlight0.size() > 0) checkOutput("data0", 32'(b0.data_o), 32'(inFlight0.pop_front()));
            end
            checkOutput("level1", 32'(b1.level_o), 32'(inFlight1.size()));
            checkOutput("level0", 32'(b0.level_o), 32'(inFlight0.size()));
        end
        applyStimulus();
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain1(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (hostQ1.size() == 0) && (inFlight1.size() == 0);
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic drain0(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (hostQ0.size() == 0) && (inFlight0.size() == 0);
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic pushRandom1(input int n);
        for (int i = 0; i < n; i++) hostQ1.push_back(8'($urandom_range(0, 255)));
        applyStimulus();
    endtask

    task automatic pushRandom0(input int n);
        for (int i = 0; i < n; i++) hostQ0.push_back(8'($urandom_range(0, 255)));
        applyStimulus();
    endtask

    initial begin
        int snapRmv, snapAdd;
        rstN = 1'b0;
        b1.enable_i = 1'b1; b1.mode_i = ECHO_PASS; b1.upFull_i = 1'b0;
        b0.enable_i = 1'b1; b0.mode_i = ECHO_PASS; b0.upFull_i = 1'b0;
        applyStimulus();
        runTicks(2);
        checkOutput("rstRmv1",   32'(b1.rmv_o),   32'd0);
        checkOutput("rstAdd1",   32'(b1.add_o),   32'd0);
        checkOutput("rstData1",  32'(b1.data_o),  32'd0);
        checkOutput("rstLevel1", 32'(b1.level_o), 32'd0);
        checkOutput("rstCount1", 32'(b1.count_o), 32'd0);
        checkOutput("rstCount0", 32'(b0.count_o), 32'd0);
        rstN = 1'b1;

        hostQ1.push_back(8'h41);
        hostQ1.push_back(8'h62);
        applyStimulus();
        drain1("drainPass", 40);
        checkOutput("countPass", 32'(b1.count_o), 32'd2);

        b1.mode_i = ECHO_CASE;
        hostQ1.push_back(8'h41); hostQ1.push_back(8'h7A); hostQ1.push_back(8'h31);
        applyStimulus();
        drain1("drainCase", 40);
        checkOutput("lastCase", 32'(b1.data_o), 32'h31);
        b1.mode_i = ECHO_INV;
        hostQ1.push_back(8'h0F);
        applyStimulus();
        drain1("drainInv", 20);
        checkOutput("lastInv", 32'(b1.data_o), 32'hF0);
        b1.mode_i = ECHO_INC;
        hostQ1.push_back(8'hFF);
        applyStimulus();
        drain1("drainInc", 20);
        checkOutput("lastInc", 32'(b1.data_o), 32'h00);

        b1.mode_i = 2'($urandom_range(0, 3));
        b1.upFull_i = 1'b1;
        snapRmv = rmvPulses1; snapAdd = addPulses1;
        pushRandom1(10);
        runTicks(40);
        checkOutput("fullRmvCount", 32'(rmvPulses1 - snapRmv), 32'd4);
        checkOutput("fullAddCount", 32'(addPulses1 - snapAdd), 32'd0);
        checkOutput("fullLevel",    32'(b1.level_o), 32'd4);
        b1.upFull_i = 1'b0;
        drain1("drainFull", 200);
        checkOutput("fullAddsAfter", 32'(addPulses1 - snapAdd), 32'd10);

        b1.upFull_i = 1'b1;
        pushRandom1(5);
        runTicks(20);
        b1.enable_i = 1'b0;
        b1.upFull_i = 1'b0;
        snapRmv = rmvPulses1; snapAdd = addPulses1;
        runTicks(20);
        checkOutput("disRmv",   32'(rmvPulses1 - snapRmv), 32'd0);
        checkOutput("disAdd",   32'(addPulses1 - snapAdd), 32'd4);
        checkOutput("disHostQ", 32'(hostQ1.size()), 32'd1);
        b1.enable_i = 1'b1;
        drain1("drainDis", 40);
        checkOutput("countModel1", 32'(b1.count_o), 32'(addsTotal1 % 65536));
        checkOutput("noBackToBack", 32'(backToBack1), 32'd0);

        b1.upFull_i = 1'b1;
        pushRandom1(3);
        runTicks(12);
        checkOutput("preRstLevel", 32'(b1.level_o), 32'd3);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("midRstLevel", 32'(b1.level_o), 32'd0);
        checkOutput("midRstAdd",   32'(b1.add_o),   32'd0);
        checkOutput("midRstRmv",   32'(b1.rmv_o),   32'd0);
        checkOutput("midRstCount", 32'(b1.count_o), 32'd0);
        b1.upFull_i = 1'b0;
        snapAdd = addPulses1;
        runTicks(20);
        checkOutput("noStaleAdd", 32'(addPulses1 - snapAdd), 32'd0);

        b0.mode_i = 2'($urandom_range(0, 3));
        rmvTicks0.delete();
        addTicks0.delete();
        pushRandom0(8);
        drain0("drainLag0", 100);
        checkOutput("lag0RmvN", 32'(rmvTicks0.size()), 32'd8);
        checkOutput("lag0AddN", 32'(addTicks0.size()), 32'd8);
        if (rmvTicks0.size() == 8 && addTicks0.size() == 8) begin
            checkOutput("lag0RmvRun", 32'(rmvTicks0[7] - rmvTicks0[0]), 32'd7);
            checkOutput("lag0AddRun", 32'(addTicks0[7] - addTicks0[0]), 32'd7);
            checkOutput("lag0Latency", 32'(addTicks0[0] - rmvTicks0[0]), 32'd1);
        end

        b0.mode_i = 2'($urandom_range(0, 3));
        pushRandom0(247);
        drain0("drainWrapA", 1000);
        checkOutput("countModel0", 32'(b0.count_o), 32'(addsTotal0 % 256));
        checkOutput("countPreWrap", 32'(b0.count_o), 32'hFF);
        pushRandom0(1);
        drain0("drainWrapB", 20);
        checkOutput("countWrap", 32'(b0.count_o), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
